// File: rtl/wbdblarbiter_pkg.sv
// Shared state encoding and configuration defaults for the dual-master Wishbone arbiter.
// Latency: n/a (types and constants only).  Backpressure: n/a.
// Imported by wbdblarbiter and wbarb_watchdog.
package wbdblarbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN_A = 2'b01,
    ARB_OWN_B = 2'b10,
    ARB_ABORT = 2'b11
  } arb_state_t;

  localparam int WBARB_TIMEOUT_DEFAULT = 1023;
  localparam int WBARB_TW_DEFAULT      = 10;

endpackage

// File: rtl/wbarb_watchdog.sv
// Bus watchdog: counts owned clocks without ACK and flags expiry at TIMEOUT.
// Latency: expiry is combinational on the clock the count reaches TIMEOUT.
// Backpressure: none; an ACK (or loss of ownership) restarts the count.
module wbarb_watchdog
  import wbdblarbiter_pkg::*;
#(
  parameter int TIMEOUT = WBARB_TIMEOUT_DEFAULT,
  parameter int TW      = WBARB_TW_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_owned,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] count;

  // An ACK arriving on the expiry clock means the slave did answer, so no abort.
  assign o_expire = i_owned && !i_ack && (count == LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_owned || i_ack) begin
      count <= '0;
    end else if (!o_expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wbdblarbiter.sv
// Two-master Wishbone arbiter: A (memory unit) has priority over B (prefetch); ownership held for a whole CYC.
// Latency: 1 clock from cyc to grant; bus signals then pass through combinationally. Optional macro WBARB_TIMEOUT_EN.
// Backpressure: the non-owner sees stall=1 until granted; the owner sees the slave's stall directly.
module wbdblarbiter
  import wbdblarbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = WBARB_TIMEOUT_DEFAULT,
  parameter int TW      = WBARB_TW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic          i_err
);

  arb_state_t state;
  logic       wd_expire;

`ifdef WBARB_TIMEOUT_EN
  logic wd_owned;
  logic abort_b;

  // Ownership ends the clock the owner drops cyc, which also restarts the count for the next owner.
  assign wd_owned = !i_rst && ((state == ARB_OWN_A && i_a_cyc) ||
                               (state == ARB_OWN_B && i_b_cyc));

  wbarb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_owned  (wd_owned),
    .i_ack    (i_ack),
    .o_expire (wd_expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0) && (TW > 0);
  assign wd_expire  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ARB_IDLE;
`ifdef WBARB_TIMEOUT_EN
      abort_b <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_a_cyc)      state <= ARB_OWN_A;
          else if (i_b_cyc) state <= ARB_OWN_B;
        end
        ARB_OWN_A: begin
          if (!i_a_cyc) begin
            state <= i_b_cyc ? ARB_OWN_B : ARB_IDLE;
          end
`ifdef WBARB_TIMEOUT_EN
          else if (wd_expire) begin
            state   <= ARB_ABORT;
            abort_b <= 1'b0;
          end
`endif
        end
        ARB_OWN_B: begin
          if (!i_b_cyc) begin
            state <= i_a_cyc ? ARB_OWN_A : ARB_IDLE;
          end
`ifdef WBARB_TIMEOUT_EN
          else if (wd_expire) begin
            state   <= ARB_ABORT;
            abort_b <= 1'b1;
          end
`endif
        end
`ifdef WBARB_TIMEOUT_EN
        ARB_ABORT: begin
          if (abort_b ? !i_b_cyc : !i_a_cyc) state <= ARB_IDLE;
        end
`endif
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Responses are qualified with the owner's cyc so a stale ACK/ERR is dropped, never rerouted.
  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = 1'b0;
    o_addr    = '0;
    o_data    = '0;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_a_stall = i_a_cyc;
    o_b_stall = i_b_cyc;
    if (!i_rst) begin
      case (state)
        ARB_OWN_A: begin
          o_cyc     = i_a_cyc;
          o_stb     = i_a_stb;
          o_we      = i_a_we;
          o_addr    = i_a_addr;
          o_data    = i_a_data;
          o_a_ack   = i_ack & i_a_cyc;
          o_a_err   = (i_err & i_a_cyc) | wd_expire;
          o_a_stall = i_stall;
          o_b_stall = 1'b1;
        end
        ARB_OWN_B: begin
          o_cyc     = i_b_cyc;
          o_stb     = i_b_stb;
          o_we      = i_b_we;
          o_addr    = i_b_addr;
          o_data    = i_b_data;
          o_b_ack   = i_ack & i_b_cyc;
          o_b_err   = (i_err & i_b_cyc) | wd_expire;
          o_b_stall = i_stall;
          o_a_stall = 1'b1;
        end
        ARB_ABORT: begin
          o_a_stall = 1'b1;
          o_b_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wbdblarbiter.sv
// Directed bench for wbdblarbiter: stimulus queues per-cycle output expectations and expected responses;
// a negedge monitor pops and compares them independently of the stimulus.
module tb_wbdblarbiter;

  localparam int AW = 32;
  localparam int F_CYC = 0, F_STB = 1, F_WE = 2, F_ADDR = 3, F_DATA = 4;
  localparam int F_AACK = 5, F_ASTL = 6, F_AERR = 7, F_BACK = 8, F_BSTL = 9, F_BERR = 10;
  localparam logic [3:0] R_AACK = 4'b1000, R_AERR = 4'b0100, R_BACK = 4'b0010;

  logic          i_clk, i_rst;
  logic          i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [31:0]   i_a_data;
  logic          o_a_ack, o_a_stall, o_a_err;
  logic          i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [31:0]   i_b_data;
  logic          o_b_ack, o_b_stall, o_b_err;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_data;
  logic          i_ack, i_stall, i_err;

  wbdblarbiter #(.AW(AW), .TIMEOUT(8), .TW(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] resp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [31:0] fld_val(input int f);
    case (f)
      F_CYC:   return {31'b0, o_cyc};
      F_STB:   return {31'b0, o_stb};
      F_WE:    return {31'b0, o_we};
      F_ADDR:  return o_addr;
      F_DATA:  return o_data;
      F_AACK:  return {31'b0, o_a_ack};
      F_ASTL:  return {31'b0, o_a_stall};
      F_AERR:  return {31'b0, o_a_err};
      F_BACK:  return {31'b0, o_b_ack};
      F_BSTL:  return {31'b0, o_b_stall};
      default: return {31'b0, o_b_err};
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ex(input string nm, input int f, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc_cnt;
    e.fld = f;
    e.val = v;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: per-cycle expectations plus every ACK/ERR the DUT presents.
  exp_t       m_e;
  logic [3:0] m_resp, m_want;
  always @(negedge i_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      m_e = exp_q.pop_front();
      n_checks++;
      if (fld_val(m_e.fld) !== m_e.val)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", m_e.nm, fld_val(m_e.fld), m_e.val, cyc_cnt);
      else
        n_pass++;
    end
    m_resp = {o_a_ack, o_a_err, o_b_ack, o_b_err};
    if (m_resp != 4'b0000) begin
      n_checks++;
      if (resp_q.size() == 0) begin
        $display("FAIL unexpected_response: got %b expected none (cycle %0d)", m_resp, cyc_cnt);
      end else begin
        m_want = resp_q.pop_front();
        if (m_resp !== m_want)
          $display("FAIL response: got %b expected %b (cycle %0d)", m_resp, m_want, cyc_cnt);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    i_rst = 1'b1;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0;
    i_ack = 0; i_stall = 0; i_err = 0;

    // Reset: outputs forced low, a requesting master still sees stall.
    tick();
    i_a_cyc = 1; i_a_stb = 1;
    ex("rst_cyc", F_CYC, 0); ex("rst_stb", F_STB, 0); ex("rst_addr", F_ADDR, 0);
    ex("rst_a_stall", F_ASTL, 1); ex("rst_b_stall", F_BSTL, 0);
    tick();
    i_a_cyc = 0; i_a_stb = 0; i_rst = 0;

    // B alone: one IDLE clock, then granted.
    tick();
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 32'h100;
    ex("t1_idle_cyc", F_CYC, 0); ex("t1_idle_b_stall", F_BSTL, 1);
    tick();
    ex("t1_grant_cyc", F_CYC, 1); ex("t1_grant_addr", F_ADDR, 32'h100); ex("t1_grant_b_stall", F_BSTL, 0);
    tick();
    i_b_stb = 0; i_ack = 1; resp_q.push_back(R_BACK);
    ex("t1_b_ack", F_BACK, 1); ex("t1_a_ack", F_AACK, 0);
    tick();
    i_ack = 0; i_b_cyc = 0;
    ex("t1_drop_cyc", F_CYC, 0);
    tick();

    // Tie: A wins, B follows with no idle clock.
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 1; i_a_addr = 32'h200; i_a_data = 32'hdeadbeef;
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 32'h300;
    ex("t2_idle_a_stall", F_ASTL, 1); ex("t2_idle_b_stall", F_BSTL, 1); ex("t2_idle_cyc", F_CYC, 0);
    tick();
    ex("t2_a_addr", F_ADDR, 32'h200); ex("t2_a_we", F_WE, 1); ex("t2_a_data", F_DATA, 32'hdeadbeef);
    ex("t2_a_stall", F_ASTL, 0); ex("t2_b_stall", F_BSTL, 1);
    tick();
    i_a_stb = 0; i_ack = 1; resp_q.push_back(R_AACK);
    ex("t2_a_ack", F_AACK, 1); ex("t2_b_noack", F_BACK, 0);
    tick();
    i_ack = 0; i_a_cyc = 0; i_a_we = 0;
    ex("t2_drop_b_stall", F_BSTL, 1); ex("t2_drop_cyc", F_CYC, 0);
    tick();
    ex("t2_b_cyc", F_CYC, 1); ex("t2_b_addr", F_ADDR, 32'h300); ex("t2_b_stall", F_BSTL, 0);
    tick();
    i_b_stb = 0; i_ack = 1; resp_q.push_back(R_BACK);
    tick();
    i_ack = 0; i_b_cyc = 0;
    tick();

    // B owns with 4 strobes; A arrives and waits for all 4 ACKs.
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 32'h400;
    tick();
    for (int i = 0; i < 4; i++) begin
      i_b_addr = 32'h400 + 32'(i);
      if (i == 1) i_a_cyc = 1;
      ex("t3_b_addr", F_ADDR, 32'h400 + 32'(i));
      if (i >= 1) ex("t3_a_stall", F_ASTL, 1);
      tick();
    end
    i_b_stb = 0;
    for (int i = 0; i < 4; i++) begin
      i_ack = 1; resp_q.push_back(R_BACK);
      ex("t3_a_noack", F_AACK, 0); ex("t3_a_stall_ack", F_ASTL, 1);
      tick();
    end
    i_ack = 0; i_b_cyc = 0;
    ex("t3_drop_a_stall", F_ASTL, 1); ex("t3_drop_cyc", F_CYC, 0);
    tick();
    ex("t3_a_grant_cyc", F_CYC, 1); ex("t3_a_grant_stall", F_ASTL, 0); ex("t3_a_grant_stb", F_STB, 0);
    tick();
    i_a_cyc = 0; i_ack = 1;   // stale ACK: owner cyc is low
    ex("t3_stale_a", F_AACK, 0); ex("t3_stale_b", F_BACK, 0);
    tick();
    i_ack = 0;
    tick();

    // A burst of 3 with slave stall for 2 clocks.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h500;
    tick();
    i_stall = 1;
    ex("t4_stall0", F_ASTL, 1); ex("t4_hold0", F_ADDR, 32'h500);
    tick();
    ex("t4_stall1", F_ASTL, 1); ex("t4_hold1", F_ADDR, 32'h500);
    tick();
    i_stall = 0;
    ex("t4_unstall", F_ASTL, 0); ex("t4_addr0", F_ADDR, 32'h500);
    tick();
    i_a_addr = 32'h501; ex("t4_addr1", F_ADDR, 32'h501);
    tick();
    i_a_addr = 32'h502; ex("t4_addr2", F_ADDR, 32'h502);
    tick();
    i_a_stb = 0;
    for (int i = 0; i < 3; i++) begin
      i_ack = 1; resp_q.push_back(R_AACK);
      ex("t4_a_ack", F_AACK, 1);
      tick();
    end
    i_ack = 0; i_a_cyc = 0;
    tick();
    tick();

    // Reset while A owns with 2 outstanding; late ACK goes nowhere.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h600;
    tick();
    tick();
    i_a_addr = 32'h601;
    tick();
    i_a_stb = 0; i_rst = 1; i_ack = 1;
    ex("t5_rst_cyc", F_CYC, 0); ex("t5_rst_a_stall", F_ASTL, 1); ex("t5_rst_a_ack", F_AACK, 0);
    tick();
    i_rst = 0;
    ex("t5_idle_cyc", F_CYC, 0); ex("t5_late_a_ack", F_AACK, 0); ex("t5_late_b_ack", F_BACK, 0);
    ex("t5_idle_a_stall", F_ASTL, 1);
    tick();
    i_a_cyc = 0; i_ack = 0;
    tick();
    tick();

`ifdef WBARB_TIMEOUT_EN
    // No ACK ever: err on the 9th owned clock, then ABORT until A drops cyc.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h700;
    tick();
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) i_a_stb = 0;
      if (k < 9) begin
        ex("t6_no_err", F_AERR, 0); ex("t6_owned_cyc", F_CYC, 1);
      end else begin
        resp_q.push_back(R_AERR);
        ex("t6_err", F_AERR, 1);
      end
      tick();
    end
    ex("t6_abort_cyc", F_CYC, 0); ex("t6_abort_a_stall", F_ASTL, 1);
    ex("t6_abort_b_stall", F_BSTL, 1); ex("t6_abort_err_pulse", F_AERR, 0);
    tick();
    ex("t6_abort_hold", F_CYC, 0);
    tick();
    i_a_cyc = 0;
    tick();
    i_b_cyc = 1;
    ex("t6_idle_cyc", F_CYC, 0); ex("t6_idle_b_stall", F_BSTL, 1);
    tick();
    ex("t6_b_grant", F_CYC, 1);
    tick();
    i_b_cyc = 0;
    tick();
`else
    // No ACK for 20 clocks: bus simply keeps waiting.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h700;
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) i_a_stb = 0;
      ex("t6_no_err", F_AERR, 0);
      if (k == 20) ex("t6_still_cyc", F_CYC, 1);
      tick();
    end
    i_ack = 1; resp_q.push_back(R_AACK);
    ex("t6_late_ack", F_AACK, 1);
    tick();
    i_ack = 0; i_a_cyc = 0;
    tick();
`endif

    tick();
    tick();
    n_checks++;
    if (resp_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL drain: got %0d responses/%0d expectations left expected 0/0", resp_q.size(), exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
